// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak-f iota round-constant generator.
//   rc_state_e    : controller states (IDLE, STEP, VALID)
//   RC_LFSR_INIT  : rc(t) LFSR seed, R[0]=1
//   rc_lfsr_step  : one step of the rc(t) LFSR; bit i of the vector is R[i]
//   rc_bit_pos    : lane bit written by LFSR output j, i.e. 2**j-1
package keccak_pkg;

    localparam int         KECCAK_L     = 6;
    localparam int         KECCAK_W     = 64;
    localparam int         KECCAK_NR    = 24;
    localparam logic [7:0] RC_LFSR_INIT = 8'h01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        VALID = 2'd2
    } rc_state_e;

    // Shift up by one; the bit falling out of R[7] re-enters at R[0] and is
    // folded into R[4], R[5] and R[6].
    function automatic logic [7:0] rc_lfsr_step(input logic [7:0] r);
        logic [7:0] n;
        n    = {r[6:0], r[7]};
        n[4] = n[4] ^ r[7];
        n[5] = n[5] ^ r[7];
        n[6] = n[6] ^ r[7];
        return n;
    endfunction

    function automatic logic [5:0] rc_bit_pos(input logic [2:0] j);
        logic [5:0] pos;
        case (j)
            3'd0:    pos = 6'd0;
            3'd1:    pos = 6'd1;
            3'd2:    pos = 6'd3;
            3'd3:    pos = 6'd7;
            3'd4:    pos = 6'd15;
            3'd5:    pos = 6'd31;
            3'd6:    pos = 6'd63;
            default: pos = 6'd0;
        endcase
        return pos;
    endfunction

endpackage

// File: rtl/keccak_rc_lfsr.sv
// 8-bit rc(t) LFSR with synchronous load and advance.
//   clk      in  clock, rising edge
//   reset    in  asynchronous active-high reset (state -> RC_LFSR_INIT)
//   load     in  reload RC_LFSR_INIT (wins over advance)
//   advance  in  take one LFSR step
//   bit0     out current rc(t) output, R[0]
module keccak_rc_lfsr
    import keccak_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic advance,
    output logic bit0
);

    logic [7:0] lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= RC_LFSR_INIT;
        end else if (load) begin
            lfsr <= RC_LFSR_INIT;
        end else if (advance) begin
            lfsr <= rc_lfsr_step(lfsr);
        end
    end

    assign bit0 = lfsr[0];

endmodule

// File: rtl/keccak_rc_gen.sv
// Sequential producer of Keccak-f iota round constants RC[ir].
// One LFSR step per STEP cycle fills lane bit 2**j-1; after seven steps the
// constant is offered to the iota stage over a valid/ready handshake.
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-high reset
//   start     in   (re)start the sequence at round 0
//   rc_ready  in   consumer accepts rc this cycle
//   rc_valid  out  rc/rc_round/rc_last hold a complete constant
//   rc        out  round constant RC[rc_round]
//   rc_round  out  round index of the presented constant
//   rc_last   out  presented constant is the final round's
//   busy      out  controller not idle
//
// state | meaning
// IDLE  | waiting for start; rc_valid low
// STEP  | one LFSR step per cycle, j = 0..6 fills rc[2**j-1]
// VALID | constant complete and held until accepted or restarted
module keccak_rc_gen
    import keccak_pkg::*;
#(
    parameter int L  = KECCAK_L,
    parameter int NR = 12 + 2 * L
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rc_ready,
    output logic              rc_valid,
    output logic [2**L-1:0]   rc,
    output logic [4:0]        rc_round,
    output logic              rc_last,
    output logic              busy
);

    localparam int         W       = 2**L;
    localparam logic [4:0] IR_LAST = 5'(NR - 1);

    rc_state_e       state, state_nxt;
    logic [2:0]      j;
    logic [4:0]      ir;
    logic [W-1:0]    rc_q;
    logic            lfsr_bit;

    logic            lfsr_load;
    logic            lfsr_adv;
    logic            round_clr;
    logic            ir_clr;
    logic            ir_inc;

    keccak_rc_lfsr u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .bit0    (lfsr_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // start has priority in every state, so an abort never completes a
    // handshake in the same cycle.
    always_comb begin
        state_nxt = state;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        round_clr = 1'b0;
        ir_clr    = 1'b0;
        ir_inc    = 1'b0;
        rc_valid  = 1'b0;
        busy      = 1'b1;
        rc_last   = 1'b0;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = STEP;
                    lfsr_load = 1'b1;
                    round_clr = 1'b1;
                    ir_clr    = 1'b1;
                end
            end
            STEP: begin
                if (start) begin
                    lfsr_load = 1'b1;
                    round_clr = 1'b1;
                    ir_clr    = 1'b1;
                end else begin
                    lfsr_adv = 1'b1;
                    if (j == 3'd6) begin
                        state_nxt = VALID;
                    end
                end
            end
            VALID: begin
                rc_valid = 1'b1;
                rc_last  = (ir == IR_LAST);
                if (start) begin
                    state_nxt = STEP;
                    lfsr_load = 1'b1;
                    round_clr = 1'b1;
                    ir_clr    = 1'b1;
                end else if (rc_ready) begin
                    if (ir == IR_LAST) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = STEP;
                        round_clr = 1'b1;
                        ir_inc    = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The LFSR is never reseeded between rounds: t = j + 7*ir is contiguous.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            j    <= 3'd0;
            rc_q <= '0;
        end else if (round_clr) begin
            j    <= 3'd0;
            rc_q <= '0;
        end else if (lfsr_adv) begin
            rc_q[rc_bit_pos(j)] <= lfsr_bit;
            j                   <= j + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir <= 5'd0;
        end else if (ir_clr) begin
            ir <= 5'd0;
        end else if (ir_inc) begin
            ir <= ir + 5'd1;
        end
    end

    assign rc       = rc_q;
    assign rc_round = ir;

endmodule

// File: tb/tb_keccak_rc_gen.sv
module tb_keccak_rc_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        rc_ready;
    logic        rc_valid;
    logic [63:0] rc;
    logic [4:0]  rc_round;
    logic        rc_last;
    logic        busy;

    always #5 clk = ~clk;

    keccak_rc_gen dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rc_ready (rc_ready),
        .rc_valid (rc_valid),
        .rc       (rc),
        .rc_round (rc_round),
        .rc_last  (rc_last),
        .busy     (busy)
    );

    int          total = 0;
    int          bad   = 0;
    logic [63:0] model_rc [24];
    logic [63:0] seen_rc  [24];
    int          exp_q[$];
    int          acc_cyc[$];
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // rc(t) straight from the FIPS 202 definition, restarting from R=1 every call.
    function automatic bit rc_bit(input int t);
        logic [8:0] r;
        r = 9'h001;
        for (int i = 1; i <= t % 255; i++) begin
            r    = r << 1;
            r[0] = r[0] ^ r[8];
            r[4] = r[4] ^ r[8];
            r[5] = r[5] ^ r[8];
            r[6] = r[6] ^ r[8];
            r[8] = 1'b0;
        end
        return r[0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every completed handshake must match the next expected round.
    always @(negedge clk) begin
        int e;
        if (!reset && rc_valid && rc_ready && !start) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got round %0d expected no constant", rc_round);
            end else begin
                e = exp_q.pop_front();
                chk("sb_rc", rc, model_rc[e]);
                chk("sb_round", 64'(rc_round), 64'(e));
                chk("sb_last", 64'(rc_last), 64'(e == 23));
                seen_rc[e] = rc;
            end
            acc_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        exp_q.delete();
        acc_cyc.delete();
        for (int i = 0; i < 24; i++) exp_q.push_back(i);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, input string nm);
        int n;
        n = 0;
        while (!rc_valid && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (!rc_valid) begin
            bad++;
            $display("FAIL %s: rc_valid still 0 after %0d cycles, expected 1", nm, budget);
        end
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL %s: busy still 1 after %0d cycles, expected 0", nm, budget);
        end
        chk({nm, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int held;
        int r;
        int gaps_ok;

        for (int ir = 0; ir < 24; ir++) begin
            model_rc[ir] = '0;
            for (int jj = 0; jj < 7; jj++) model_rc[ir][(1 << jj) - 1] = rc_bit(jj + 7 * ir);
        end

        // Reset state
        reset    = 1'b1;
        start    = 1'b0;
        rc_ready = 1'b0;
        repeat (3) tick();
        chk("rst_valid", 64'(rc_valid), 64'd0);
        chk("rst_busy",  64'(busy),     64'd0);
        chk("rst_rc",    rc,            64'd0);
        chk("rst_last",  64'(rc_last),  64'd0);
        chk("rst_round", 64'(rc_round), 64'd0);
        reset = 1'b0;
        tick();

        // T1 + T2: first-constant latency, full run with ready tied high
        rc_ready = 1'b1;
        do_start();
        chk("t1_lat_e0", 64'(rc_valid), 64'd0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("t1_lat_e%0d", k), 64'(rc_valid), 64'(k == 7));
        end
        chk("t1_rc0", rc, 64'h0000000000000001);
        chk("t1_round0", 64'(rc_round), 64'd0);
        wait_idle(400, "t2_idle");
        chk("t2_rc1",  seen_rc[1],  64'h0000000000008082);
        chk("t2_rc2",  seen_rc[2],  64'h800000000000808A);
        chk("t2_rc23", seen_rc[23], 64'h8000000080008008);
        chk("t2_naccept", 64'(acc_cyc.size()), 64'd24);
        gaps_ok = 1;
        for (int i = 1; i < acc_cyc.size(); i++)
            if (acc_cyc[i] - acc_cyc[i-1] != 8) gaps_ok = 0;
        chk("t2_throughput_8", 64'(gaps_ok), 64'd1);
        r = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rc_valid || busy) r = 1;
        end
        chk("t2_no_wrap", 64'(r), 64'd0);

        // T3: random ready (ignored while invalid), 20-cycle stall at round 3
        rc_ready = 1'b0;
        do_start();
        held = 0;
        for (int n = 0; n < 1500 && busy; n++) begin
            if (rc_valid && rc_round == 5'd3 && held == 0) begin
                held = 1;
                rc_ready = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    tick();
                    chk("t3_hold_rc", rc, 64'h8000000080008000);
                    chk("t3_hold_valid", 64'(rc_valid), 64'd1);
                end
                rc_ready = 1'b1;
            end else begin
                rc_ready = 1'($urandom_range(0, 1));
            end
            tick();
        end
        chk("t3_stalled", 64'(held), 64'd1);
        wait_idle(50, "t3_idle");

        // T4: abort in STEP of round 5
        rc_ready = 1'b1;
        do_start();
        for (int n = 0; n < 200 && !(rc_valid && rc_round == 5'd4); n++) tick();
        tick();
        repeat ($urandom_range(0, 5)) tick();
        chk("t4_in_step", 64'(rc_valid), 64'd0);
        do_start();
        wait_valid(10, "t4_valid");
        chk("t4_rc0", rc, 64'h0000000000000001);
        chk("t4_round0", 64'(rc_round), 64'd0);
        wait_idle(400, "t4_idle");

        // T5: reset while presenting round 10
        rc_ready = 1'b1;
        do_start();
        for (int n = 0; n < 300; n++) begin
            if (rc_valid && rc_round == 5'd10) break;
            tick();
        end
        rc_ready = 1'b0;
        chk("t5_at_r10", 64'(rc_round), 64'd10);
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("t5_valid", 64'(rc_valid), 64'd0);
        chk("t5_rc",    rc,            64'd0);
        chk("t5_round", 64'(rc_round), 64'd0);
        chk("t5_last",  64'(rc_last),  64'd0);
        chk("t5_busy",  64'(busy),     64'd0);
        tick();
        reset = 1'b0;
        tick();
        rc_ready = 1'b1;
        do_start();
        wait_valid(10, "t5_valid_after");
        chk("t5_rc0", rc, 64'h0000000000000001);
        wait_idle(400, "t5_idle");

        // T6: start and rc_ready together while presenting a random round
        r = $urandom_range(1, 20);
        rc_ready = 1'b1;
        do_start();
        for (int n = 0; n < 300; n++) begin
            if (rc_valid && rc_round == 5'(r)) break;
            tick();
        end
        chk("t6_at_r", 64'(rc_round), 64'(r));
        do_start();
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("t6_lat_e%0d", k), 64'(rc_valid), 64'(k == 7));
        end
        chk("t6_round0", 64'(rc_round), 64'd0);
        chk("t6_rc0", rc, 64'h0000000000000001);
        wait_idle(400, "t6_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
